// File: rtl/run_ctrl_pkg.sv
// run_ctrl_pkg: shared types and constants for the run controller.
//   state_t        - controller FSM states
//   START_HOLD_DEF - default core_start hold length in cycles
//   TIMEOUT_DEF    - default RUN-cycle limit before a run counts as hung
//   CNT_W / ID_W   - widths of cycle_count and run_id
package run_ctrl_pkg;
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_RUN,
        S_DONE,
        S_TIMEOUT
    } state_t;
    localparam int CNT_W = 16;
    localparam int ID_W = 8;
    localparam int START_HOLD_DEF = 4;
    localparam logic [CNT_W-1:0] TIMEOUT_DEF = 16'd10000;
endpackage

// File: rtl/run_ctrl_if.sv
// run_ctrl_if: request/status bundle between a host and run_ctrl.
//   go, abort, core_done - host/core to controller
//   core_start, busy, run_done, timed_out, cycle_count, run_id - controller to host/core
//   master: host side, slave: controller side
interface run_ctrl_if;
    import run_ctrl_pkg::*;
    logic go;
    logic abort;
    logic core_done;
    logic core_start;
    logic busy;
    logic run_done;
    logic timed_out;
    logic [CNT_W-1:0] cycle_count;
    logic [ID_W-1:0] run_id;
    modport master (
        output go, abort, core_done,
        input  core_start, busy, run_done, timed_out, cycle_count, run_id
    );
    modport slave (
        input  go, abort, core_done,
        output core_start, busy, run_done, timed_out, cycle_count, run_id
    );
endinterface

// File: rtl/run_ctrl_cyc_counter.sv
// cyc_counter: RUN-cycle counter with synchronous clear and terminal-count flag.
//   clock, reset - clock and asynchronous active-high reset
//   clear        - zero the count (takes priority over en)
//   en           - advance the count by one
//   count        - current count
//   tc           - high when count equals LIMIT-1 (the last cycle before timeout)
module cyc_counter
    import run_ctrl_pkg::*;
#(
    parameter logic [CNT_W-1:0] LIMIT = TIMEOUT_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             tc
);
    assign tc = count == LIMIT - CNT_W'(1);
    always_ff @(posedge clock or posedge reset) begin
        if (reset) count <= '0;
        else if (clear) count <= '0;
        else if (en) count <= count + CNT_W'(1);
    end
endmodule

// File: rtl/run_ctrl.sv
// run_ctrl: sequences a processor core through start, run, completion and timeout.
//   clock, reset - clock and asynchronous active-high reset
//   bus (slave)  - go/abort/core_done in; core_start/busy/run_done/timed_out,
//                  cycle_count (RUN cycles of current/last run), run_id (completed runs) out
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int START_HOLD = START_HOLD_DEF,
    parameter logic [CNT_W-1:0] TIMEOUT = TIMEOUT_DEF
) (
    input logic clock,
    input logic reset,
    run_ctrl_if.slave bus
);
    localparam logic [7:0] HOLD_INIT = 8'(START_HOLD);
    state_t state, next_state;
    logic [7:0] hold;
    logic [ID_W-1:0] run_id;
    logic start_run, finish, tc;
    assign start_run = bus.go && (state == S_IDLE || state == S_DONE || state == S_TIMEOUT);
    assign finish = state == S_RUN && !bus.abort && bus.core_done;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_IDLE;
        else state <= next_state;
    end
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE, S_DONE, S_TIMEOUT: next_state = bus.go ? S_START : state;
            S_START: next_state = bus.abort ? S_IDLE : (hold == 8'd1 ? S_RUN : S_START);
            S_RUN: next_state = bus.abort ? S_IDLE : bus.core_done ? S_DONE : tc ? S_TIMEOUT : S_RUN;
            default: next_state = S_IDLE;
        endcase
    end
    always_comb begin
        bus.core_start = state == S_START;
        bus.busy = state == S_START || state == S_RUN;
        bus.run_done = state == S_DONE;
        bus.timed_out = state == S_TIMEOUT;
    end
    // hold counts down the remaining START cycles; it leaves START on the cycle it reads 1
    always_ff @(posedge clock or posedge reset) begin
        if (reset) hold <= '0;
        else if (start_run) hold <= HOLD_INIT;
        else if (state == S_START) hold <= hold - 8'd1;
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) run_id <= '0;
        else if (finish) run_id <= run_id + ID_W'(1);
    end
    assign bus.run_id = run_id;
    // counting stops on abort or completion so cycle_count keeps the run's final value
    cyc_counter #(.LIMIT(TIMEOUT)) u_cnt (
        .clock (clock),
        .reset (reset),
        .clear (start_run),
        .en    (state == S_RUN && !bus.abort && !bus.core_done),
        .count (bus.cycle_count),
        .tc    (tc)
    );
endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl: directed self-checking bench for run_ctrl (START_HOLD=4, TIMEOUT=100).
module tb_run_ctrl;
    logic clock;
    logic reset;
    int n_asserts = 0;
    int n_fail = 0;
    run_ctrl_if bus ();
    run_ctrl #(.START_HOLD(4), .TIMEOUT(16'd100)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end
    function automatic logic [31:0] flags();
        return {28'd0, bus.core_start, bus.busy, bus.run_done, bus.timed_out};
    endfunction
    function automatic logic [31:0] cnt();
        return 32'(bus.cycle_count);
    endfunction
    function automatic logic [31:0] rid();
        return 32'(bus.run_id);
    endfunction
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask
    initial begin
        reset = 1'b0;
        bus.go = 1'b0;
        bus.abort = 1'b0;
        bus.core_done = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("reset_flags", flags(), 32'b0000);
        chk("reset_count", cnt(), 32'd0);
        chk("reset_id", rid(), 32'd0);
        tick(2);
        reset = 1'b0;
        // normal run: core_done on the 10th RUN cycle
        bus.go = 1'b1;
        tick(1);
        bus.go = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            chk($sformatf("run1_flags_c%0d", c), flags(), c <= 4 ? 32'b1100 : 32'b0100);
            chk($sformatf("run1_count_c%0d", c), cnt(), c <= 5 ? 32'd0 : 32'(c - 5));
            if (c == 14) bus.core_done = 1'b1;
            tick(1);
        end
        bus.core_done = 1'b0;
        chk("run1_done_flags", flags(), 32'b0010);
        chk("run1_done_count", cnt(), 32'd9);
        chk("run1_done_id", rid(), 32'd1);
        bus.abort = 1'b1;
        tick(1);
        bus.abort = 1'b0;
        chk("abort_in_done_flags", flags(), 32'b0010);
        chk("abort_in_done_count", cnt(), 32'd9);
        // timeout: core_done never asserted
        bus.go = 1'b1;
        tick(1);
        bus.go = 1'b0;
        tick(103);
        chk("to_last_flags", flags(), 32'b0100);
        chk("to_last_count", cnt(), 32'd99);
        tick(1);
        chk("to_flags", flags(), 32'b0001);
        chk("to_count", cnt(), 32'd100);
        chk("to_id", rid(), 32'd1);
        tick(1);
        chk("to_stable_flags", flags(), 32'b0001);
        chk("to_stable_count", cnt(), 32'd100);
        // core_done exactly at the final pre-timeout cycle
        bus.go = 1'b1;
        tick(1);
        bus.go = 1'b0;
        tick(103);
        chk("edge_count", cnt(), 32'd99);
        bus.core_done = 1'b1;
        tick(1);
        bus.core_done = 1'b0;
        chk("edge_flags", flags(), 32'b0010);
        chk("edge_count_held", cnt(), 32'd99);
        chk("edge_id", rid(), 32'd2);
        // go mid-run is ignored, then abort at count 5
        bus.go = 1'b1;
        tick(1);
        bus.go = 1'b0;
        tick(7);
        bus.go = 1'b1;
        tick(1);
        bus.go = 1'b0;
        tick(1);
        chk("pre_abort_flags", flags(), 32'b0100);
        chk("pre_abort_count", cnt(), 32'd5);
        bus.abort = 1'b1;
        tick(1);
        bus.abort = 1'b0;
        chk("abort_flags", flags(), 32'b0000);
        chk("abort_count", cnt(), 32'd5);
        chk("abort_id", rid(), 32'd2);
        tick(1);
        chk("abort_idle_flags", flags(), 32'b0000);
        // back-to-back runs with go and core_done held high: DONE every 6 cycles
        bus.go = 1'b1;
        bus.core_done = 1'b1;
        tick(6);
        chk("b2b_first_flags", flags(), 32'b0010);
        chk("b2b_first_id", rid(), 32'd3);
        chk("b2b_first_count", cnt(), 32'd0);
        tick(1);
        chk("b2b_restart_flags", flags(), 32'b1100);
        tick(1511);
        chk("b2b_255_flags", flags(), 32'b0010);
        chk("b2b_255_id", rid(), 32'd255);
        tick(1);
        chk("b2b_one_cycle_done", flags(), 32'b1100);
        tick(5);
        chk("b2b_wrap_flags", flags(), 32'b0010);
        chk("b2b_wrap_id", rid(), 32'd0);
        tick(12);
        chk("b2b_256_id", rid(), 32'd2);
        bus.go = 1'b0;
        bus.core_done = 1'b0;
        tick(1);
        chk("b2b_hold_done", flags(), 32'b0010);
        chk("b2b_hold_id", rid(), 32'd2);
        // asynchronous reset mid-RUN
        bus.go = 1'b1;
        tick(1);
        bus.go = 1'b0;
        tick(9);
        chk("pre_reset_count", cnt(), 32'd5);
        #2 reset = 1'b1;
        #1;
        chk("async_flags", flags(), 32'b0000);
        chk("async_count", cnt(), 32'd0);
        chk("async_id", rid(), 32'd0);
        tick(1);
        reset = 1'b0;
        bus.go = 1'b1;
        tick(1);
        bus.go = 1'b0;
        tick(13);
        bus.core_done = 1'b1;
        tick(1);
        bus.core_done = 1'b0;
        chk("post_reset_flags", flags(), 32'b0010);
        chk("post_reset_count", cnt(), 32'd9);
        chk("post_reset_id", rid(), 32'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
